// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

    // Instruction presented to IF/ID when no valid instruction is available (bubble).
    localparam logic [31:0] ZEROWORD = 32'h0000_0000;
    // Sequential fetch increment (one 32-bit word).
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Fetch FSM encodings.
    typedef enum logic {
        FETCH_S_REQ  = 1'b0,
        FETCH_S_WAIT = 1'b1
    } fetch_state_e;

    // One buffered fetch: the address it was fetched from and the returned word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Clear the byte-offset bits so that every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of {pc,instr} pairs between instruction memory and IF/ID.
// Flush beats push; a push into a full FIFO is accepted only alongside a pop.
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being read out this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array; contents are don't-care until covered by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one word fetch at a time
// over req/gnt + rvalid, buffers returned words and presents the head to IF/ID.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag,
    input  logic [31:0] jump_addr,
    input  logic        load_use_flag,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_if_o,
    output logic [31:0] instr_if_o,
    output logic        instr_valid_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e   state;
    fetch_state_e   state_nxt;
    logic [31:0]    fetch_pc;
    logic [31:0]    fetch_addr_q;   // address of the fetch currently in flight
    logic           outstanding;
    logic           outstanding_nxt;
    logic           drop_cnt;       // responses still owed to a squashed stream

    logic           credit_ok;
    logic           fire_gnt;
    logic           fire_rsp;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_empty;
    logic           fifo_full;
    logic [CW-1:0]  fifo_count;
    fetch_entry_t   fifo_din;
    fetch_entry_t   fifo_dout;

    // A request is only raised when the returning word is guaranteed a slot.
    assign credit_ok = !fifo_full &&
                       ((32'(fifo_count) + 32'(outstanding)) < 32'(DEPTH));
    assign fire_gnt  = imem_req && imem_gnt;
    assign fire_rsp  = (state == FETCH_S_WAIT) && imem_rvalid;

    // Grant and response are mutually exclusive since they live in different states.
    assign outstanding_nxt = fire_gnt ? 1'b1 : (fire_rsp ? 1'b0 : outstanding);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH_S_REQ;
        else     state <= state_nxt;
    end

    // FSM next state: request until granted, then wait for the data beat.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_S_REQ:  if (fire_gnt)    state_nxt = FETCH_S_WAIT;
            FETCH_S_WAIT: if (imem_rvalid) state_nxt = FETCH_S_REQ;
            default:                       state_nxt = FETCH_S_REQ;
        endcase
    end

    // FSM outputs; the request is held low while reset is asserted.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        if (state == FETCH_S_REQ && !rst) imem_req = credit_ok;
    end

    // Fetch PC, in-flight address and drop bookkeeping; a jump overrides the step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            outstanding  <= 1'b0;
            drop_cnt     <= 1'b0;
        end else begin
            if (fire_gnt) fetch_addr_q <= fetch_pc;

            if (jump_flag)     fetch_pc <= word_align(jump_addr);
            else if (fire_gnt) fetch_pc <= fetch_pc + PC_STEP;

            outstanding <= outstanding_nxt;

            // Everything still in flight after this edge belongs to the old stream.
            if (jump_flag)                 drop_cnt <= outstanding_nxt;
            else if (fire_rsp && drop_cnt) drop_cnt <= 1'b0;
        end
    end

    // A response landing in a jump cycle is old-stream data and never buffered.
    assign fifo_push = fire_rsp && !drop_cnt && !jump_flag;
    assign fifo_pop  = instr_valid_o && !load_use_flag && !jump_flag;
    assign fifo_din  = '{pc: fetch_addr_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (jump_flag),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign instr_valid_o = !fifo_empty;
    assign pc_if_o       = instr_valid_o ? fifo_dout.pc    : 32'h0;
    assign instr_if_o    = instr_valid_o ? fifo_dout.instr : ZEROWORD;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed + table-driven bench for if_fetch_unit. Memory returns addr>>2 as data.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_use_flag;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_if_o;
    logic [31:0] instr_if_o;
    logic        instr_valid_o;

    // second instance exercising address wrap from the top of memory
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_valid;
    logic        w_pend;
    logic [31:0] w_addr_q;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag     (jump_flag),
        .jump_addr     (jump_addr),
        .load_use_flag (load_use_flag),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .pc_if_o       (pc_if_o),
        .instr_if_o    (instr_if_o),
        .instr_valid_o (instr_valid_o)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .jump_flag     (1'b0),
        .jump_addr     (32'h0),
        .load_use_flag (1'b0),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_gnt      (w_gnt),
        .imem_rvalid   (w_rvalid),
        .imem_rdata    (w_rdata),
        .pc_if_o       (w_pc),
        .instr_if_o    (w_instr),
        .instr_valid_o (w_valid)
    );

    // ---------------- memory models ----------------
    bit          rnd_mode;
    int          fix_rv;
    int          g_cnt;
    int          r_cnt;
    logic        mem_pend;
    logic [31:0] mem_addr_q;

    assign imem_gnt    = imem_req && (g_cnt == 0);
    assign imem_rvalid = mem_pend && (r_cnt == 0);
    assign imem_rdata  = mem_addr_q >> 2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_pend <= 1'b0;
            g_cnt    <= 0;
            r_cnt    <= 0;
        end else begin
            if (imem_gnt) begin
                mem_pend   <= 1'b1;
                mem_addr_q <= imem_addr;
                r_cnt      <= rnd_mode ? int'($urandom_range(0, 4)) : fix_rv;
                g_cnt      <= rnd_mode ? int'($urandom_range(0, 5)) : 0;
            end else if (imem_req && g_cnt > 0) begin
                g_cnt <= g_cnt - 1;
            end
            if (imem_rvalid)              mem_pend <= 1'b0;
            else if (mem_pend && r_cnt > 0) r_cnt <= r_cnt - 1;
        end
    end

    assign w_gnt    = w_req;
    assign w_rvalid = w_pend;
    assign w_rdata  = w_addr_q >> 2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            w_pend <= 1'b0;
        end else begin
            w_pend <= w_gnt;
            if (w_gnt) w_addr_q <= w_addr;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } obs_t;

    obs_t        obs[$];
    obs_t        wobs[$];
    bit          rnd_chk;
    logic [31:0] exp_next;
    int          pops;
    int          viol;

    // Records every instruction consumed by IF/ID; in random mode checks it
    // against a reference PC stream (sequential, restarted by each jump).
    always @(negedge clk) begin
        if (!rst && instr_valid_o && !load_use_flag && !jump_flag) begin
            obs.push_back('{pc: pc_if_o, instr: instr_if_o});
            if (rnd_chk) begin
                chk("rnd_pc", pc_if_o, exp_next);
                chk("rnd_instr", instr_if_o, pc_if_o >> 2);
                exp_next = exp_next + 32'd4;
                pops++;
            end
        end
        if (rnd_chk && !rst && jump_flag) exp_next = jump_addr & ~32'h3;
        if (rnd_chk && !rst) begin
            if (imem_gnt && mem_pend) viol++;                       // second fetch in flight
            if (32'(u_dut.u_fifo.count) > 32'd2) viol++;
            if (32'(u_dut.u_fifo.count) == 32'd2 && imem_req) viol++;
        end
        if (!rst && w_valid && wobs.size() < 2) wobs.push_back('{pc: w_pc, instr: w_instr});
    end

    // ---------------- table vectors ----------------
    typedef struct {
        logic        lu;
        logic        jmp;
        logic [31:0] jaddr;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    localparam int NVEC = 24;
    vec_t tbl [NVEC];

    function automatic vec_t v(input logic lu, input logic jmp, input logic [31:0] jaddr,
                               input logic req, input logic [31:0] addr,
                               input logic vld, input logic [31:0] pc);
        vec_t r;
        r.lu = lu; r.jmp = jmp; r.jaddr = jaddr;
        r.req = req; r.addr = addr; r.vld = vld; r.pc = pc;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        load_use_flag = 1'b0;
        jump_flag = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] exp_instr;

        rst = 1'b1; load_use_flag = 1'b0; jump_flag = 1'b0; jump_addr = 32'h0;
        rnd_mode = 1'b0; fix_rv = 0; rnd_chk = 1'b0; exp_next = 32'h0; pops = 0; viol = 0;

        // 1-cycle memory: fetch and response alternate, so the head toggles valid.
        //            lu    jmp   jaddr     req   addr      vld   pc
        tbl[0]  = v(1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000);
        tbl[1]  = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h004, 1'b0, 32'h000);
        tbl[2]  = v(1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h000);
        tbl[3]  = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b0, 32'h000);
        tbl[4]  = v(1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004);
        tbl[5]  = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h00C, 1'b0, 32'h000);
        tbl[6]  = v(1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h008);  // stall begins
        tbl[7]  = v(1'b1, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008);
        tbl[8]  = v(1'b1, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008);  // full
        tbl[9]  = v(1'b1, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008);
        tbl[10] = v(1'b1, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008);
        tbl[11] = v(1'b1, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008);
        tbl[12] = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008);  // released
        tbl[13] = v(1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h00C);
        tbl[14] = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h014, 1'b0, 32'h000);
        tbl[15] = v(1'b0, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h010);
        tbl[16] = v(1'b0, 1'b1, 32'h103, 1'b0, 32'h018, 1'b0, 32'h000);  // jump + rvalid
        tbl[17] = v(1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000);
        tbl[18] = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h000);
        tbl[19] = v(1'b0, 1'b1, 32'h201, 1'b1, 32'h104, 1'b1, 32'h100);  // jump + gnt
        tbl[20] = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h200, 1'b0, 32'h000);
        tbl[21] = v(1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000);
        tbl[22] = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h204, 1'b0, 32'h000);
        tbl[23] = v(1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200);

        // ---- reset values ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   32'(imem_req), 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_pc",    pc_if_o, 32'h0);
        chk("rst_instr", instr_if_o, 32'h0);
        chk("rst_valid", 32'(instr_valid_o), 32'h0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        chk("rst_wrap_req",  32'(w_req), 32'h0);

        // ---- table: sequential fetch, stall, jump/rvalid and jump/gnt collisions ----
        rst = 1'b0;
        for (int k = 0; k < NVEC; k++) begin
            load_use_flag = tbl[k].lu;
            jump_flag     = tbl[k].jmp;
            jump_addr     = tbl[k].jaddr;
            @(negedge clk);
            exp_instr = tbl[k].vld ? (tbl[k].pc >> 2) : 32'h0;
            chk($sformatf("vec%0d_req", k),   32'(imem_req), 32'(tbl[k].req));
            chk($sformatf("vec%0d_addr", k),  imem_addr, tbl[k].addr);
            chk($sformatf("vec%0d_valid", k), 32'(instr_valid_o), 32'(tbl[k].vld));
            chk($sformatf("vec%0d_pc", k),    pc_if_o, tbl[k].pc);
            chk($sformatf("vec%0d_instr", k), instr_if_o, exp_instr);
            @(posedge clk); #1;
        end
        load_use_flag = 1'b0;
        jump_flag = 1'b0;

        // ---- wrap instance: first two fetches straddle the top of memory ----
        if (wobs.size() < 2) begin
            fail_timeout("wrap_stream");
        end else begin
            chk("wrap_pc0",    wobs[0].pc, 32'hFFFF_FFFC);
            chk("wrap_instr0", wobs[0].instr, 32'h3FFF_FFFF);
            chk("wrap_pc1",    wobs[1].pc, 32'h0000_0000);
            chk("wrap_instr1", wobs[1].instr, 32'h0000_0000);
        end

        // ---- jump while waiting on a slow response ----
        fix_rv = 2;
        do_reset();
        load_use_flag = 1'b1;
        n = 0;
        while (!instr_valid_o && n < 20) begin @(posedge clk); #1; n++; end
        while (!(imem_req && imem_gnt) && n < 40) begin @(posedge clk); #1; n++; end
        if (n >= 40) fail_timeout("jw_setup");
        @(posedge clk); #1;
        obs.delete();
        jump_flag = 1'b1;
        jump_addr = 32'h103;
        @(posedge clk); #1;
        jump_flag = 1'b0;
        load_use_flag = 1'b0;
        @(negedge clk);
        chk("jw_empty", 32'(instr_valid_o), 32'h0);
        chk("jw_addr",  imem_addr, 32'h100);
        n = 0;
        while (obs.size() < 2 && n < 40) begin @(posedge clk); #1; n++; end
        if (obs.size() < 2) begin
            fail_timeout("jw_stream");
        end else begin
            chk("jw_pc0",    obs[0].pc, 32'h100);
            chk("jw_instr0", obs[0].instr, 32'h40);
            chk("jw_pc1",    obs[1].pc, 32'h104);
        end

        // ---- random gnt/rvalid latency with random stalls and jumps ----
        rnd_mode = 1'b1;
        exp_next = 32'h0;
        do_reset();
        rnd_chk = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            load_use_flag = ($urandom_range(0, 3) == 0);
            jump_flag     = ($urandom_range(0, 30) == 0);
            jump_addr     = $urandom;
            @(posedge clk); #1;
        end
        load_use_flag = 1'b0;
        jump_flag = 1'b0;
        @(negedge clk);
        rnd_chk = 1'b0;
        chk("rnd_bound_violations", 32'(viol), 32'h0);
        chk("rnd_progress", 32'(pops >= 100), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
